// File: rtl/usb_rx_packet_parser.sv
// USB receive packet parser: PID/length/CRC validation, token decode and payload streaming.
// Define RX_STATS_EN to add saturating good/bad packet counters with a synchronous clear.
module usb_rx_packet_parser #(
  parameter int unsigned MAX_BYTES = 64
) (
  input  logic                   HPS_USB_CLKOUT,
  input  logic                   resetN,
  input  logic [8*MAX_BYTES-1:0] rxBuffer,
  input  logic [8:0]             rxSize,
  input  logic                   rxValid,
  output logic [3:0]             pidOut,
  output logic [1:0]             pktType,
  output logic [6:0]             tokenAddr,
  output logic [3:0]             tokenEndp,
  output logic                   pktDone,
  output logic                   errPid,
  output logic                   errLen,
  output logic                   errCrc,
  output logic [7:0]             payloadByte,
  output logic                   payloadValid,
  input  logic                   payloadReady,
  output logic                   payloadLast,
  output logic                   busy
`ifdef RX_STATS_EN
  ,
  input  logic                   statClear,
  output logic [15:0]            statGood,
  output logic [15:0]            statBad
`endif
);

  localparam logic [1:0]  TypeToken     = 2'd0;
  localparam logic [1:0]  TypeData      = 2'd1;
  localparam logic [1:0]  TypeHandshake = 2'd2;
  localparam logic [1:0]  TypeSpecial   = 2'd3;
  localparam logic [8:0]  MaxSize       = 9'(MAX_BYTES);
  localparam logic [15:0] Crc16Init     = 16'hFFFF;

  typedef enum logic [2:0] {S_IDLE, S_PID, S_CRC5, S_CRC16, S_EMIT, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic                   rx_valid_q;
  logic [8*MAX_BYTES-1:0] buf_q;
  logic [8:0]             size_q;
  logic [6:0]             idx_q, idx_d;
  logic [15:0]            crc_q, crc_d;
  logic                   err_pid_q, err_pid_d;
  logic                   err_len_q, err_len_d;
  logic                   err_crc_q, err_crc_d;
  logic [1:0]             type_q, type_d;
  logic [3:0]             pid_out_q;
  logic [1:0]             pkt_type_q;
  logic [6:0]             token_addr_q, token_addr_d;
  logic [3:0]             token_endp_q, token_endp_d;

  logic                   rise, load, enter_done;
  logic [1:0]             cls;
  logic [7:0]             cur_byte;
  logic [6:0]             payload_end, hi_idx, lo_idx;
  logic [15:0]            crc_rx, crc_next;

  function automatic logic [4:0] crc5_calc(input logic [10:0] d);
    logic [4:0] c;
    c = 5'h1F;
    for (int i = 0; i < 11; i++) begin
      if (c[0] ^ d[i]) c = (c >> 1) ^ 5'h14;
      else             c = c >> 1;
    end
    return ~c;
  endfunction

  function automatic logic [15:0] crc16_byte(input logic [15:0] c_in, input logic [7:0] b);
    logic [15:0] c;
    c = c_in;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ b[i]) c = (c >> 1) ^ 16'hA001;
      else             c = c >> 1;
    end
    return c;
  endfunction

  assign rise        = rxValid & ~rx_valid_q;
  assign load        = (state_q == S_IDLE) && rise;
  assign enter_done  = (state_d == S_DONE) && (state_q != S_DONE);
  assign cur_byte    = buf_q[8*idx_q +: 8];
  assign payload_end = size_q[6:0] - 7'd3;
  assign hi_idx      = size_q[6:0] - 7'd1;
  assign lo_idx      = size_q[6:0] - 7'd2;
  // Received CRC16 travels low byte first
  assign crc_rx      = {buf_q[8*hi_idx +: 8], buf_q[8*lo_idx +: 8]};
  assign crc_next    = crc16_byte(crc_q, cur_byte);

  always_comb begin
    cls = TypeSpecial;
    case (buf_q[7:0])
      8'hD2, 8'h5A, 8'h1E, 8'h96: cls = TypeHandshake;
      8'hE1, 8'h69, 8'h2D, 8'hA5: cls = TypeToken;
      8'hC3, 8'h4B, 8'h87, 8'h0F: cls = TypeData;
      default: ;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    crc_d        = crc_q;
    err_pid_d    = err_pid_q;
    err_len_d    = err_len_q;
    err_crc_d    = err_crc_q;
    type_d       = type_q;
    token_addr_d = token_addr_q;
    token_endp_d = token_endp_q;
    unique case (state_q)
      S_IDLE: begin
        if (rise) state_d = S_PID;
      end
      S_PID: begin
        type_d  = cls;
        state_d = S_DONE;
        if (size_q == 9'd0 || size_q > MaxSize) begin
          err_len_d = 1'b1;
        end else if (buf_q[3:0] != ~buf_q[7:4]) begin
          err_pid_d = 1'b1;
        end else begin
          unique case (cls)
            TypeHandshake: err_len_d = (size_q != 9'd1);
            TypeToken: begin
              if (size_q != 9'd3) err_len_d = 1'b1;
              else                state_d   = S_CRC5;
            end
            TypeData: begin
              if (size_q < 9'd3) begin
                err_len_d = 1'b1;
              end else if (size_q == 9'd3) begin
                err_crc_d = (crc_rx != ~Crc16Init);
              end else begin
                idx_d   = 7'd1;
                crc_d   = Crc16Init;
                state_d = S_CRC16;
              end
            end
            default: ;
          endcase
        end
      end
      S_CRC5: begin
        token_addr_d = buf_q[14:8];
        token_endp_d = {buf_q[18:16], buf_q[15]};
        err_crc_d    = (crc5_calc({buf_q[18:16], buf_q[15:8]}) != buf_q[23:19]);
        state_d      = S_DONE;
      end
      S_CRC16: begin
        crc_d = crc_next;
        if (idx_q == payload_end) begin
          if (~crc_next != crc_rx) begin
            err_crc_d = 1'b1;
            state_d   = S_DONE;
          end else begin
            idx_d   = 7'd1;
            state_d = S_EMIT;
          end
        end else begin
          idx_d = idx_q + 7'd1;
        end
      end
      S_EMIT: begin
        if (payloadReady) begin
          if (idx_q == payload_end) state_d = S_DONE;
          else                      idx_d   = idx_q + 7'd1;
        end
      end
      S_DONE: begin
        err_pid_d = 1'b0;
        err_len_d = 1'b0;
        err_crc_d = 1'b0;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge HPS_USB_CLKOUT or negedge resetN) begin
    if (!resetN) begin
      state_q      <= S_IDLE;
      rx_valid_q   <= 1'b0;
      buf_q        <= '0;
      size_q       <= '0;
      idx_q        <= '0;
      crc_q        <= '0;
      err_pid_q    <= 1'b0;
      err_len_q    <= 1'b0;
      err_crc_q    <= 1'b0;
      type_q       <= '0;
      pid_out_q    <= '0;
      pkt_type_q   <= '0;
      token_addr_q <= '0;
      token_endp_q <= '0;
    end else begin
      state_q      <= state_d;
      rx_valid_q   <= rxValid;
      idx_q        <= idx_d;
      crc_q        <= crc_d;
      err_pid_q    <= err_pid_d;
      err_len_q    <= err_len_d;
      err_crc_q    <= err_crc_d;
      type_q       <= type_d;
      token_addr_q <= token_addr_d;
      token_endp_q <= token_endp_d;
      if (load) begin
        buf_q  <= rxBuffer;
        size_q <= rxSize;
      end
      // Loaded on the way into S_DONE so they are valid alongside pktDone
      if (enter_done) begin
        pid_out_q  <= buf_q[3:0];
        pkt_type_q <= type_d;
      end
    end
  end

  assign pidOut       = pid_out_q;
  assign pktType      = pkt_type_q;
  assign tokenAddr    = token_addr_q;
  assign tokenEndp    = token_endp_q;
  assign pktDone      = (state_q == S_DONE);
  assign errPid       = err_pid_q;
  assign errLen       = err_len_q;
  assign errCrc       = err_crc_q;
  assign payloadValid = (state_q == S_EMIT);
  assign payloadByte  = payloadValid ? cur_byte : 8'h00;
  assign payloadLast  = payloadValid && (idx_q == payload_end);
  assign busy         = (state_q != S_IDLE);

`ifdef RX_STATS_EN
  logic [15:0] stat_good_q, stat_bad_q;
  logic        pkt_err;

  assign pkt_err = err_pid_q | err_len_q | err_crc_q;

  always_ff @(posedge HPS_USB_CLKOUT or negedge resetN) begin
    if (!resetN) begin
      stat_good_q <= '0;
      stat_bad_q  <= '0;
    end else if (statClear) begin
      stat_good_q <= '0;
      stat_bad_q  <= '0;
    end else if (pktDone) begin
      if (pkt_err) begin
        if (stat_bad_q != 16'hFFFF) stat_bad_q <= stat_bad_q + 16'd1;
      end else begin
        if (stat_good_q != 16'hFFFF) stat_good_q <= stat_good_q + 16'd1;
      end
    end
  end

  assign statGood = stat_good_q;
  assign statBad  = stat_bad_q;
`endif

endmodule
